// File: rtl/mac_job_scheduler_pkg.sv
// Shared types for the MAC job scheduler: the job descriptor layout and
// the dispatcher state encoding.
package mac_job_scheduler_pkg;

    // One MAC job as handed from a requester to the MAC controller.
    typedef struct packed {
        logic [31:0] a_addr;
        logic [31:0] b_addr;
        logic [31:0] c_addr;
        logic [31:0] d_addr;
        logic [15:0] len;
        logic [4:0]  shift;
        logic        simple_mul;
    } mac_job_t;

    // Width of the packed descriptor as carried on the job buses and in the FIFO.
    localparam int MAC_JOB_W = $bits(mac_job_t);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_START,
        DS_RUN,
        DS_DONE
    } ds_state_t;

endpackage

// File: rtl/mac_job_scheduler_if.sv
// Bundles the requester side and the MAC controller side of the scheduler.
// Signal names carry the direction as seen from the scheduler.
interface mac_job_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4
);
    import mac_job_scheduler_pkg::*;

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0]           req_valid_i;
    logic [N_REQ-1:0]           req_ready_o;
    mac_job_t [N_REQ-1:0]       req_job_i;
    logic                       eng_start_o;
    mac_job_t                   eng_job_o;
    logic                       eng_done_i;
    logic [N_REQ-1:0]           evt_o;
    logic                       busy_o;
    logic [OCC_W-1:0]           occupancy_o;

    modport slave (
        input  req_valid_i,
        input  req_job_i,
        input  eng_done_i,
        output req_ready_o,
        output eng_start_o,
        output eng_job_o,
        output evt_o,
        output busy_o,
        output occupancy_o
    );

    modport master (
        output req_valid_i,
        output req_job_i,
        output eng_done_i,
        input  req_ready_o,
        input  eng_start_o,
        input  eng_job_o,
        input  evt_o,
        input  busy_o,
        input  occupancy_o
    );

endinterface

// File: rtl/mac_job_scheduler_fifo.sv
// Synchronous FIFO holding {job, requester id} entries. A push while full is
// accepted when a pop happens in the same cycle, since the slot being read
// is released at the same edge the new entry is written.
module mac_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array: written on every accepted push, never reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Next pointer and fill-level values; pointers wrap through the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and fill-level registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// Job front-end for the MAC accelerator: round-robin arbitration across the
// requesters into a job FIFO, and a dispatcher that runs one job at a time
// on the MAC controller and signals completion back to the owner.
module mac_job_scheduler
    import mac_job_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    mac_job_scheduler_if.slave   bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = MAC_JOB_W + ID_W;

    logic              sreset;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand_sum;
    logic [ID_W-1:0]   cand;
    logic [N_REQ-1:0]  req_ready;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_wdata;
    logic [ENT_W-1:0]  fifo_rdata;
    logic [OCC_W-1:0]  fifo_count;

    ds_state_t         state_q;
    mac_job_t          job_q;
    logic [ID_W-1:0]   id_q;
    logic              start_q;
    logic [N_REQ-1:0]  evt_q;

    // Hard reset and soft clear have identical effect.
    assign sreset = rst_i | clear_i;

    // The dispatcher pulls the head whenever it is idle and something is queued.
    assign fifo_pop = (state_q == DS_IDLE) && !fifo_empty;

    // Pick the first valid requester at or after the round-robin pointer.
    // A full FIFO still has room when the dispatcher pops in the same cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        if (!sreset && (!fifo_full || fifo_pop)) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (cand_sum >= (ID_W+1)'(N_REQ)) begin
                    cand_sum = cand_sum - (ID_W+1)'(N_REQ);
                end
                cand = cand_sum[ID_W-1:0];
                if (!grant_vld && bus.req_valid_i[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // One-hot ready towards the granted requester, plus the pointer advance.
    always_comb begin
        req_ready = '0;
        rr_ptr_d  = rr_ptr_q;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
            rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (sreset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign fifo_push  = grant_vld;
    assign fifo_wdata = {bus.req_job_i[grant_idx], grant_idx};

    mac_job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (sreset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Dispatcher: pop a job, pulse start, wait for done, then raise the owner's event.
    always_ff @(posedge clk_i) begin
        if (sreset) begin
            state_q <= DS_IDLE;
            job_q   <= '0;
            id_q    <= '0;
            start_q <= 1'b0;
            evt_q   <= '0;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    evt_q <= '0;
                    if (fifo_pop) begin
                        job_q   <= mac_job_t'(fifo_rdata[ENT_W-1:ID_W]);
                        id_q    <= fifo_rdata[ID_W-1:0];
                        start_q <= 1'b1;
                        state_q <= DS_START;
                    end
                end
                DS_START: begin
                    start_q <= 1'b0;
                    state_q <= DS_RUN;
                end
                DS_RUN: begin
                    if (bus.eng_done_i) begin
                        evt_q   <= N_REQ'(1) << id_q;
                        state_q <= DS_DONE;
                    end
                end
                DS_DONE: begin
                    evt_q   <= '0;
                    state_q <= DS_IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    evt_q   <= '0;
                    state_q <= DS_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.eng_start_o = start_q;
    assign bus.eng_job_o   = job_q;
    assign bus.evt_o       = evt_q;
    assign bus.busy_o      = !fifo_empty || (state_q != DS_IDLE);
    assign bus.occupancy_o = fifo_count;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Bench for mac_job_scheduler: directed scenarios plus a randomized run,
// all compared against a queue-and-timeline model of the scheduler.
module tb_mac_job_scheduler;
    import mac_job_scheduler_pkg::*;

    localparam int N_REQ = 4;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    typedef struct {
        mac_job_t job;
        int       id;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    mac_job_scheduler_if #(.N_REQ(N_REQ), .DEPTH(DEPTH)) bus();

    mac_job_scheduler #(.N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: queued jobs, rotation pointer, and the timeline of the held job.
    ent_t      mq[$];
    int        m_rr;
    bit        m_hold;
    int        m_pop_cyc;
    int        m_done_cyc;
    mac_job_t  m_job;
    int        m_id;
    int        cyc;
    bit        m_pop_now;
    int        m_grant;

    logic [N_REQ-1:0] exp_ready;
    logic             exp_start;
    logic [N_REQ-1:0] exp_evt;
    mac_job_t         exp_job;
    logic [OCC_W-1:0] exp_occ;
    logic             exp_busy;

    function automatic mac_job_t rand_job();
        mac_job_t j;
        j.a_addr     = $urandom();
        j.b_addr     = $urandom();
        j.c_addr     = $urandom();
        j.d_addr     = $urandom();
        j.len        = 16'($urandom_range(0, 255));
        j.shift      = 5'($urandom_range(0, 31));
        j.simple_mul = 1'($urandom_range(0, 1));
        return j;
    endfunction

    task automatic model_eval();
        int r;
        m_pop_now = !m_hold && (mq.size() > 0);
        m_grant   = -1;
        if (!rst && !clear && (mq.size() < DEPTH || m_pop_now)) begin
            for (int k = 0; k < N_REQ; k++) begin
                r = (m_rr + k) % N_REQ;
                if (m_grant < 0 && bus.req_valid_i[r] === 1'b1) m_grant = r;
            end
        end
        exp_ready = '0;
        if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
        exp_start = m_hold && (cyc == m_pop_cyc + 1);
        exp_evt   = '0;
        if (m_hold && m_done_cyc >= 0 && cyc == m_done_cyc + 1) exp_evt[m_id] = 1'b1;
        exp_job  = m_job;
        exp_occ  = OCC_W'(mq.size());
        exp_busy = (mq.size() > 0) || m_hold;
    endtask

    task automatic model_advance();
        ent_t e;
        bit   evt_end;
        if (rst || clear) begin
            mq.delete();
            m_rr   = 0;
            m_hold = 0;
            m_job  = '0;
            m_id   = 0;
            cyc++;
            return;
        end
        evt_end = m_hold && m_done_cyc >= 0 && cyc == m_done_cyc + 1;
        if (m_hold && m_done_cyc < 0 && cyc >= m_pop_cyc + 2 && bus.eng_done_i === 1'b1)
            m_done_cyc = cyc;
        if (m_pop_now) begin
            e          = mq.pop_front();
            m_job      = e.job;
            m_id       = e.id;
            m_hold     = 1;
            m_pop_cyc  = cyc;
            m_done_cyc = -1;
        end
        if (m_grant >= 0) begin
            e.job = bus.req_job_i[m_grant];
            e.id  = m_grant;
            mq.push_back(e);
            m_rr = (m_grant + 1) % N_REQ;
        end
        if (evt_end) m_hold = 0;
        cyc++;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        bus.req_valid_i = '0;
        bus.eng_done_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = '1;
        settle();
        total++;
        if (bus.req_ready_o !== '0) begin
            bad++;
            $display("[TB] FAIL reset_ready_in_reset got=%b exp=0", bus.req_ready_o);
        end
        tick();
        tick();
        bus.req_valid_i = '0;
        rst = 1'b0;
        settle();
        total++;
        if (bus.eng_start_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_start got=%b exp=0", bus.eng_start_o); end
        total++;
        if (bus.evt_o !== '0) begin bad++; $display("[TB] FAIL reset_evt got=%b exp=0", bus.evt_o); end
        total++;
        if (bus.eng_job_o !== '0) begin bad++; $display("[TB] FAIL reset_job got=%h exp=0", bus.eng_job_o); end
        total++;
        if (bus.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy_o); end
        total++;
        if (bus.occupancy_o !== '0) begin bad++; $display("[TB] FAIL reset_occ got=%0d exp=0", bus.occupancy_o); end
    endtask

    task automatic test_single_job();
        mac_job_t j;
        do_reset();
        j = rand_job();
        j.len = 16'd16;
        j.a_addr = 32'h0000_1000;
        bus.req_job_i[2] = j;
        bus.req_valid_i = 4'b0100;
        settle();
        total++;
        if (bus.req_ready_o !== 4'b0100) begin bad++; $display("[TB] FAIL single_ready got=%b exp=0100", bus.req_ready_o); end
        tick();
        bus.req_valid_i = '0;
        settle();
        total++;
        if (bus.eng_start_o !== 1'b0) begin bad++; $display("[TB] FAIL single_start_early got=%b exp=0", bus.eng_start_o); end
        tick();
        settle();
        total++;
        if (bus.eng_start_o !== 1'b1) begin bad++; $display("[TB] FAIL single_start got=%b exp=1", bus.eng_start_o); end
        total++;
        if (bus.eng_job_o.a_addr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL single_a_addr got=%h exp=00001000", bus.eng_job_o.a_addr); end
        total++;
        if (bus.eng_job_o !== j) begin bad++; $display("[TB] FAIL single_job got=%h exp=%h", bus.eng_job_o, j); end
        tick();
        settle();
        total++;
        if (bus.eng_start_o !== 1'b0) begin bad++; $display("[TB] FAIL single_start_width got=%b exp=0", bus.eng_start_o); end
        tick();
        bus.eng_done_i = 1'b1;
        settle();
        total++;
        if (bus.evt_o !== '0) begin bad++; $display("[TB] FAIL single_evt_early got=%b exp=0", bus.evt_o); end
        tick();
        bus.eng_done_i = 1'b0;
        settle();
        total++;
        if (bus.evt_o !== 4'b0100) begin bad++; $display("[TB] FAIL single_evt got=%b exp=0100", bus.evt_o); end
        tick();
        tick();
        settle();
        total++;
        if (bus.evt_o !== '0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_after got evt=%b busy=%b exp evt=0 busy=0", bus.evt_o, bus.busy_o);
        end
    endtask

    task automatic test_spurious_done();
        do_reset();
        bus.eng_done_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if (bus.evt_o !== '0 || bus.busy_o !== 1'b0 || bus.eng_start_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL spur_idle c=%0d evt=%b busy=%b start=%b exp all 0", c, bus.evt_o, bus.busy_o, bus.eng_start_o);
            end
            tick();
        end
        bus.eng_done_i = 1'b0;
        bus.req_job_i[1] = rand_job();
        bus.req_valid_i = 4'b0010;
        tick();
        bus.req_valid_i = '0;
        bus.eng_done_i = 1'b1;
        tick();
        settle();
        total++;
        if (bus.eng_start_o !== 1'b1) begin bad++; $display("[TB] FAIL spur_start got=%b exp=1", bus.eng_start_o); end
        tick();
        bus.eng_done_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if (bus.evt_o !== '0 || bus.busy_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL spur_run c=%0d evt=%b busy=%b exp evt=0 busy=1", c, bus.evt_o, bus.busy_o);
            end
            tick();
        end
        bus.eng_done_i = 1'b1;
        tick();
        bus.eng_done_i = 1'b0;
        settle();
        total++;
        if (bus.evt_o !== 4'b0010) begin bad++; $display("[TB] FAIL spur_evt got=%b exp=0010", bus.evt_o); end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int exp_seq[9];
        int obs;
        logic [N_REQ-1:0] rdy;
        exp_seq = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
        do_reset();
        for (int r = 0; r < N_REQ; r++) bus.req_job_i[r] = rand_job();
        bus.req_valid_i = '1;
        bus.eng_done_i = 1'b1;
        for (int c = 0; c < 200 && grants.size() < 9; c++) begin
            settle();
            total++;
            if (bus.req_ready_o !== exp_ready) begin
                bad++;
                $display("[TB] FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready_o, exp_ready);
            end
            rdy = bus.req_ready_o;
            obs = -1;
            for (int r = 0; r < N_REQ; r++) if (rdy[r] === 1'b1 && obs < 0) obs = r;
            if (obs >= 0) grants.push_back(obs);
            tick();
            if (obs >= 0) bus.req_job_i[obs] = rand_job();
            if (grants.size() >= 5) bus.req_valid_i[1] = 1'b0;
        end
        total++;
        if (grants.size() != 9) begin bad++; $display("[TB] FAIL rr_timeout got=%0d exp=9 grants", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            total++;
            if (grants[i] != exp_seq[i]) begin
                bad++;
                $display("[TB] FAIL rr_order i=%0d got=%0d exp=%0d", i, grants[i], exp_seq[i]);
            end
        end
        bus.req_valid_i = '0;
        bus.eng_done_i = 1'b0;
    endtask

    task automatic test_full_fifo();
        mac_job_t jl[6];
        logic [OCC_W-1:0] occ_exp[12];
        logic [N_REQ-1:0] rdy;
        bit reload0;
        bit reload1;
        int idx;
        occ_exp = '{0, 1, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4};
        reload0 = 0;
        reload1 = 0;
        do_reset();
        for (int i = 0; i < 6; i++) jl[i] = rand_job();
        for (int r = 0; r < N_REQ; r++) bus.req_job_i[r] = jl[r];
        bus.req_valid_i = '1;
        for (int c = 0; c < 12; c++) begin
            settle();
            total++;
            if (bus.occupancy_o !== occ_exp[c]) begin
                bad++;
                $display("[TB] FAIL full_occ c=%0d got=%0d exp=%0d", c, bus.occupancy_o, occ_exp[c]);
            end
            total++;
            if (bus.req_ready_o !== exp_ready) begin
                bad++;
                $display("[TB] FAIL full_ready c=%0d got=%b exp=%b", c, bus.req_ready_o, exp_ready);
            end
            if (c >= 5) begin
                total++;
                if (bus.req_ready_o !== '0) begin
                    bad++;
                    $display("[TB] FAIL full_ready_zero c=%0d got=%b exp=0", c, bus.req_ready_o);
                end
            end
            rdy = bus.req_ready_o;
            tick();
            for (int r = 0; r < N_REQ; r++) begin
                if (rdy[r] === 1'b1) begin
                    if (r == 0 && !reload0) begin
                        bus.req_job_i[0] = jl[4];
                        reload0 = 1;
                    end else if (r == 1 && !reload1) begin
                        bus.req_job_i[1] = jl[5];
                        reload1 = 1;
                    end else begin
                        bus.req_valid_i[r] = 1'b0;
                    end
                end
            end
        end
        bus.eng_done_i = 1'b1;
        tick();
        bus.eng_done_i = 1'b0;
        settle();
        total++;
        if (bus.evt_o !== 4'b0001) begin bad++; $display("[TB] FAIL full_evt got=%b exp=0001", bus.evt_o); end
        tick();
        settle();
        total++;
        if (bus.req_ready_o !== 4'b0010) begin bad++; $display("[TB] FAIL full_refill_ready got=%b exp=0010", bus.req_ready_o); end
        total++;
        if (bus.occupancy_o !== OCC_W'(4)) begin bad++; $display("[TB] FAIL full_refill_occ got=%0d exp=4", bus.occupancy_o); end
        tick();
        bus.req_valid_i = '0;
        settle();
        total++;
        if (bus.occupancy_o !== OCC_W'(4)) begin bad++; $display("[TB] FAIL full_pushpop_occ got=%0d exp=4", bus.occupancy_o); end
        bus.eng_done_i = 1'b1;
        idx = 1;
        for (int c = 0; c < 60 && idx < 6; c++) begin
            settle();
            if (bus.eng_start_o === 1'b1) begin
                total++;
                if (bus.eng_job_o !== jl[idx]) begin
                    bad++;
                    $display("[TB] FAIL full_drain_order i=%0d got=%h exp=%h", idx, bus.eng_job_o, jl[idx]);
                end
                idx++;
            end
            tick();
        end
        total++;
        if (idx != 6) begin bad++; $display("[TB] FAIL full_drain_timeout got=%0d exp=6 starts", idx); end
        bus.eng_done_i = 1'b0;
    endtask

    task automatic test_mid_job_clear();
        logic [N_REQ-1:0] rdy;
        do_reset();
        for (int r = 0; r < N_REQ; r++) bus.req_job_i[r] = rand_job();
        bus.req_valid_i = '1;
        for (int c = 0; c < 4; c++) begin
            settle();
            rdy = bus.req_ready_o;
            tick();
            bus.req_valid_i = bus.req_valid_i & ~rdy;
        end
        settle();
        total++;
        if (bus.occupancy_o !== OCC_W'(3) || bus.busy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clear_pre occ=%0d busy=%b exp occ=3 busy=1", bus.occupancy_o, bus.busy_o);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        settle();
        total++;
        if (bus.busy_o !== 1'b0 || bus.occupancy_o !== '0) begin
            bad++;
            $display("[TB] FAIL clear_post busy=%b occ=%0d exp busy=0 occ=0", bus.busy_o, bus.occupancy_o);
        end
        total++;
        if (bus.eng_job_o !== '0 || bus.eng_start_o !== 1'b0 || bus.evt_o !== '0) begin
            bad++;
            $display("[TB] FAIL clear_outputs job=%h start=%b evt=%b exp all 0", bus.eng_job_o, bus.eng_start_o, bus.evt_o);
        end
        bus.eng_done_i = 1'b1;
        tick();
        bus.eng_done_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            total++;
            if (bus.evt_o !== '0 || bus.busy_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL clear_late_done c=%0d evt=%b busy=%b exp evt=0 busy=0", c, bus.evt_o, bus.busy_o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (bus.req_valid_i[r] !== 1'b1 && $urandom_range(0, 2) == 0) begin
                    bus.req_job_i[r] = rand_job();
                    bus.req_valid_i[r] = 1'b1;
                end
            end
            bus.eng_done_i = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 149) == 0);
            settle();
            total++;
            if (bus.req_ready_o !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready_o, exp_ready); end
            total++;
            if (bus.eng_start_o !== exp_start) begin bad++; $display("[TB] FAIL rnd_start c=%0d got=%b exp=%b", c, bus.eng_start_o, exp_start); end
            total++;
            if (bus.evt_o !== exp_evt) begin bad++; $display("[TB] FAIL rnd_evt c=%0d got=%b exp=%b", c, bus.evt_o, exp_evt); end
            total++;
            if (bus.eng_job_o !== exp_job) begin bad++; $display("[TB] FAIL rnd_job c=%0d got=%h exp=%h", c, bus.eng_job_o, exp_job); end
            total++;
            if (bus.occupancy_o !== exp_occ) begin bad++; $display("[TB] FAIL rnd_occ c=%0d got=%0d exp=%0d", c, bus.occupancy_o, exp_occ); end
            total++;
            if (bus.busy_o !== exp_busy) begin bad++; $display("[TB] FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy_o, exp_busy); end
            rdy = bus.req_ready_o;
            tick();
            clear = 1'b0;
            bus.req_valid_i = bus.req_valid_i & ~rdy;
        end
        bus.req_valid_i = '0;
        bus.eng_done_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        bus.req_valid_i = '0;
        bus.eng_done_i = 1'b0;
        for (int r = 0; r < N_REQ; r++) bus.req_job_i[r] = '0;
        m_rr = 0;
        m_hold = 0;
        m_pop_cyc = 0;
        m_done_cyc = -1;
        m_job = '0;
        m_id = 0;
        cyc = 0;
        #1;
        $display("[TB] starting mac_job_scheduler bench");
        test_reset();
        test_single_job();
        test_spurious_done();
        test_round_robin();
        test_full_fifo();
        test_mid_job_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
